// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule generator.
//
// On start, the cipher key is expanded forward to the round-10 key, one round per cycle. The
// round keys are then emitted from round 10 down to round 0 through a valid/ready handshake.
// Each accepted key is rolled back one round in place. No 11-entry key store is needed.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high reset
//   start     request a new schedule (honoured only when idle)
//   key_in    128-bit cipher key, captured when start is accepted
//   rk_ready  consumer accepts rk_out
//   busy      schedule in progress (from start acceptance to final handshake)
//   rk_valid  rk_out / rk_round hold a valid round key
//   rk_out    round key, w0 = [127:96] ... w3 = [31:0]
//   rk_round  round index of rk_out, 10 down to 0
//   done      one-cycle pulse after the round-0 handshake

`timescale 1ns/1ps

module aes_inv_key_sched (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         busy,
   output logic         rk_valid,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         done
);

   typedef enum logic [1:0] {StIdle, StExpand, StEmit} state_e;

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   ctr_q, ctr_d;
   logic         done_q, done_d;

   // GF(2^8) arithmetic, polynomial x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = gf_mul(a, a);
      for (int i = 1; i < 8; i++) begin
         r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   // S-box = affine transform of the field inverse
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] w1p, w2p, w3p;
   logic [31:0] sbox_in, sub_rot, t;
   logic [3:0]  rcon_idx;
   logic [31:0] f0, f1, f2, f3;
   logic [127:0] fwd_key, inv_key;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // The inverse step recovers the previous w1..w3 from XOR chaining alone.
   assign w3p = w3 ^ w2;
   assign w2p = w2 ^ w1;
   assign w1p = w1 ^ w0;

   // The single shared S-box word serves both directions. The forward step feeds it the
   // current w3. The inverse step feeds it the recovered previous w3.
   assign sbox_in  = (state_q == StEmit) ? w3p : w3;
   assign sub_rot  = sub_word({sbox_in[23:0], sbox_in[31:24]});
   assign rcon_idx = (state_q == StExpand) ? ctr_q + 4'd1 : ctr_q;
   assign t        = sub_rot ^ {rcon(rcon_idx), 24'h000000};

   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   assign fwd_key = {f0, f1, f2, f3};
   assign inv_key = {w0 ^ t, w1p, w2p, w3p};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      ctr_d   = ctr_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d   = key_in;
               ctr_d   = 4'd0;
               state_d = StExpand;
            end
         end
         StExpand: begin
            key_d = fwd_key;
            ctr_d = ctr_q + 4'd1;
            if (ctr_q == 4'd9) state_d = StEmit;
         end
         StEmit: begin
            if (rk_ready) begin
               if (ctr_q != 4'd0) begin
                  key_d = inv_key;
                  ctr_d = ctr_q - 4'd1;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         key_q   <= '0;
         ctr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         ctr_q   <= ctr_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign rk_valid = (state_q == StEmit);
   assign rk_out   = rk_valid ? key_q : '0;
   assign rk_round = rk_valid ? ctr_q : '0;
   assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
`timescale 1ns/1ps

module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] key_in;
   logic         rk_ready = 1'b1;
   logic         busy;
   logic         rk_valid;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         done;

   always #5 clk = ~clk;

   aes_inv_key_sched dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .key_in   (key_in),
      .rk_ready (rk_ready),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .done     (done)
   );

   localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit bp_en  = 1'b0;

   typedef struct {
      logic [3:0]   round;
      logic [127:0] key;
      int           first_cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] sbox_tbl[256];

   always @(posedge clk) cyc++;

   // Consumer: always ready unless random backpressure is enabled.
   always @(posedge clk) begin
      #1;
      rk_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   function automatic logic [31:0] sub_word_m(input logic [31:0] w);
      return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
   endfunction

   // Reference model: full FIPS-197 forward expansion into w[0..43]. Round r is w[4r..4r+3].
   // Expected keys are queued in emission order (10 down to 0).
   task automatic push_schedule(input logic [127:0] key, input int first_cyc);
      logic [31:0] w[44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      exp_t        e;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 10; r >= 0; r--) begin
         e.round     = r[3:0];
         e.key       = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         e.first_cyc = (r == 10) ? first_cyc : -1;
         exp_q.push_back(e);
      end
   endtask

   // Called at posedge+#1 with the DUT idle; the next edge accepts.
   task automatic issue(input logic [127:0] k);
      push_schedule(k, cyc + 11);
      start  = 1'b1;
      key_in = k;
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Busy must hold until done. Returns at posedge+#1 of the done cycle.
   task automatic wait_done(input string name);
      for (int i = 0; i < 600; i++) begin
         if (done) return;
         chk({name, "_busy"}, 128'(busy), 128'(1));
         @(posedge clk); #1;
      end
      fail_now(name, "timeout waiting for done");
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 100; i++) begin
         if (rk_valid) return;
         @(posedge clk); #1;
      end
      fail_now(name, "timeout waiting for rk_valid");
   endtask

   // Monitor / scoreboard
   logic         prev_valid = 1'b0;
   logic         prev_stall = 1'b0;
   logic         exp_done   = 1'b0;
   logic         stall_run  = 1'b0;
   int           run_len    = 0;
   logic [127:0] held_key;
   logic [3:0]   held_round;
   exp_t         me;

   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
         exp_done   = 1'b0;
         stall_run  = 1'b0;
         run_len    = 0;
      end else begin
         if (exp_done || done) begin
            chk("done_pulse", 128'(done), 128'(exp_done));
            if (exp_done) chk("busy_in_done", 128'(busy), 128'(0));
         end
         exp_done = 1'b0;
         if (prev_stall) begin
            chk("stall_valid", 128'(rk_valid), 128'(1));
            chk("stall_key", rk_out, held_key);
            chk("stall_round", 128'(rk_round), 128'(held_round));
         end
         if (rk_valid) begin
            chk("busy_valid", 128'(busy), 128'(1));
            if (!prev_valid) begin
               run_len   = 0;
               stall_run = 1'b0;
               if (exp_q.size() > 0 && exp_q[0].first_cyc >= 0)
                  chk("first_valid_cycle", 128'(cyc), 128'(exp_q[0].first_cyc));
            end
            run_len++;
            if (rk_ready) begin
               prev_stall = 1'b0;
               if (exp_q.size() == 0) begin
                  fail_now("extra_key", $sformatf("round %0d key %h not expected",
                                                  rk_round, rk_out));
               end else begin
                  me = exp_q.pop_front();
                  chk("rk_round", 128'(rk_round), 128'(me.round));
                  chk("rk_out", rk_out, me.key);
                  if (me.round == 4'd0) exp_done = 1'b1;
               end
            end else begin
               prev_stall = 1'b1;
               stall_run  = 1'b1;
               held_key   = rk_out;
               held_round = rk_round;
            end
         end else begin
            prev_stall = 1'b0;
            if (prev_valid && !stall_run) chk("valid_run_len", 128'(run_len), 128'(11));
         end
         prev_valid = rk_valid;
      end
   end

   initial begin
      logic [2047:0] flat;
      logic [127:0]  k;
      flat = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
              128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
              128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
              128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
              128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
              128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
              128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
              128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int i = 0; i < 256; i++) sbox_tbl[i] = flat[2047-8*i -: 8];

      reset  = 1'b1;
      start  = 1'b0;
      key_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_valid", 128'(rk_valid), 128'(0));
      chk("reset_done", 128'(done), 128'(0));
      chk("reset_rk_out", rk_out, 128'(0));
      chk("reset_rk_round", 128'(rk_round), 128'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      // FIPS-197 key with the consumer always ready
      issue(FipsKey);
      wait_valid("fips_valid");
      chk("fips_round10_idx", 128'(rk_round), 128'(10));
      chk("fips_round10_key", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(posedge clk); #1;
      chk("fips_round9_key", rk_out, 128'hac7766f319fadc2128d12941575c006e);
      wait_done("fips");
      @(posedge clk); #1;

      // Random backpressure: same key, then random keys
      bp_en = 1'b1;
      issue(FipsKey);
      wait_done("bp_fips");
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         issue({$urandom, $urandom, $urandom, $urandom});
         wait_done("bp_rand");
      end
      bp_en = 1'b0;
      @(posedge clk); #1;

      // start is ignored during EXPAND and EMIT
      issue({$urandom, $urandom, $urandom, $urandom});
      repeat (3) @(posedge clk);
      #1;
      start  = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      start  = 1'b0;
      wait_valid("ign_valid");
      repeat (2) @(posedge clk);
      #1;
      start  = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      start  = 1'b0;
      wait_done("ignore_start");
      @(posedge clk); #1;

      // Reset while round 5 is presented, then an all-zero key
      issue({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 100; i++) begin
         if (rk_valid && rk_round == 4'd5) break;
         @(posedge clk); #1;
      end
      chk("reset_at_round5", 128'(rk_round), 128'(5));
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_busy", 128'(busy), 128'(0));
      chk("midreset_valid", 128'(rk_valid), 128'(0));
      chk("midreset_done", 128'(done), 128'(0));
      chk("midreset_rk_out", rk_out, 128'(0));
      chk("midreset_rk_round", 128'(rk_round), 128'(0));
      exp_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      issue(128'(0));
      wait_valid("zero_valid");
      chk("zero_round10_key", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      wait_done("zero_key");

      // Back-to-back schedules started in the done cycle
      @(posedge clk); #1;
      issue({$urandom, $urandom, $urandom, $urandom});
      for (int n = 0; n < 3; n++) begin
         wait_done("b2b");
         if (n == 1) bp_en = 1'b1;
         k = {$urandom, $urandom, $urandom, $urandom};
         issue(k);
      end
      wait_done("b2b_last");
      bp_en = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001: The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002: Ports SHALL be as follows (clock and reset first):
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new key schedule.
- key_in  input  128  AES-128 cipher key, sampled when start is accepted.
- rk_ready  input  1  consumer accepts rk_out.
- busy  output  1  high from start acceptance until the final handshake.
- rk_valid  output  1  rk_out/rk_round hold a valid round key.
- rk_out  output  128  round key; word w0 = [127:96], w3 = [31:0].
- rk_round  output  4  round index of rk_out, 10 down to 0.
- done  output  1  one-cycle pulse after the round-0 key handshake.

Function
REQ-003: States SHALL be IDLE, EXPAND and EMIT.
REQ-004: In IDLE with start=1, on the rising edge the block SHALL load key_in into the key register, clear the round counter, set busy=1 and enter EXPAND.
REQ-005: start SHALL be ignored in EXPAND and EMIT.
REQ-006: In EXPAND, each cycle SHALL apply one forward step with rcon(ctr+1) and then increment ctr.
REQ-007: Forward step:
- t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
- w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
REQ-008: RotWord({b0,b1,b2,b3}) SHALL equal {b1,b2,b3,b0}, with b0 as the MS byte.
REQ-009: SubWord SHALL apply the AES S-box to each of the four bytes.
REQ-010: rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-011: After 10 EXPAND cycles (ctr=10) the block SHALL enter EMIT. The first rk_valid SHALL therefore appear 10 cycles after the edge that accepts start.
REQ-012: In EMIT, rk_valid=1, rk_out=key register and rk_round=ctr.
REQ-013: While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL remain stable, with no limit on the stall length.
REQ-014: On an EMIT handshake (rk_valid & rk_ready) with ctr>0, the block SHALL apply one inverse step with rcon(ctr) and decrement ctr.
REQ-015: Inverse step:
- w3p = w3^w2; w2p = w2^w1; w1p = w1^w0
- w0p = w0 ^ SubWord(RotWord(w3p)) ^ {rcon,24'h0}
REQ-016: On an EMIT handshake with ctr=0, the block SHALL enter IDLE, drop rk_valid and busy, and assert done for exactly one cycle.
REQ-017: A start in the IDLE cycle where done=1 SHALL be accepted; back-to-back schedules are allowed.
REQ-018: rk_ready while rk_valid=0 SHALL have no effect.
REQ-019: One S-box word instance SHALL be shared between the forward and inverse paths, with its input muxed by state.
REQ-020: With rk_ready held at 1, rk_valid SHALL be high for exactly 11 consecutive cycles.

Reset
REQ-021: On reset=1 at a rising edge, regardless of state, the block SHALL enter IDLE and set:
- busy, rk_valid, done = 0
- rk_out = 0, rk_round = 0
- key register = 0, ctr = 0
REQ-022: Reset SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-023: FIPS-197 key, rk_ready=1.
- Stimulus: key_in = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
- Response: the first valid cycle gives rk_round=10, rk_out = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Response: the next cycle gives rk_round=9, rk_out = ac7766f3 19fadc21 28d12941 575c006e.
- Response: rk_round=1 gives a0fafe17 88542cb1 23a33939 2a6c7605.
- Response: rk_round=0 gives key_in, then done pulses once.
REQ-024: Random backpressure, same key with rk_ready randomised.
- Response: the same 11 keys in the same order.
- Response: outputs stable during every stall.
- Response: no key dropped or duplicated.
REQ-025: start during EXPAND and during EMIT.
- Response: ignored; the key sequence is unchanged.
REQ-026: Reset mid-operation.
- Stimulus: reset while rk_round=5 is presented.
- Response: all outputs 0 on the following cycle.
- Follow-up stimulus: start with key_in = 0.
- Response: round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e; round 0 = all zeros.
REQ-027: Back-to-back schedules.
- Stimulus: start asserted during the done cycle with a new key.
- Response: the second schedule's round-10 key appears 10 cycles later.
- Response: busy stays high except for the done cycle.
